// File: rtl/shift_rnd_rne.sv
// shift_rnd_rne: variable arithmetic right shift with RNE rounding and saturation.
// Optional input register stage: define SHIFT_RND_RNE_IN_REG_EN.
module shift_rnd_rne #(
    parameter int width_i     = 9,
    parameter int width_o     = 8,
    parameter int width_shift = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [width_i-1:0]     i_num,
    input  logic [width_shift-1:0] i_shift,
    output logic [width_o-1:0]     o_rnd
);
    localparam int wn = width_i + 2;
    localparam int wt = width_shift + $clog2(width_i + 2) + 1;
    localparam int wi = $clog2(wn + 1);
    localparam logic [wt-1:0] s_max = wt'(width_i + 1);
    localparam logic signed [wn:0] max_v = (wn + 1)'((1 << (width_o - 1)) - 1);
    localparam logic signed [wn:0] min_v = ~max_v;

    logic [width_i-1:0]     num_r;
    logic [width_shift-1:0] shift_r;
    logic [wt-1:0]          s_tot;
    logic [wi-1:0]          sc;
    logic signed [wn-1:0]   ne;
    logic signed [wn-1:0]   kept;
    logic [wn:0]            ext;
    logic [wn:0]            mask;
    logic                   guard;
    logic                   sticky;
    logic                   inc;
    logic signed [wn:0]     rnd;
    logic [width_o-1:0]     sat;

`ifdef SHIFT_RND_RNE_IN_REG_EN
    // capture operands ahead of the rounding logic
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            num_r   <= '0;
            shift_r <= '0;
        end else begin
            num_r   <= i_num;
            shift_r <= i_shift;
        end
    end
`else
    assign num_r   = i_num;
    assign shift_r = i_shift;
`endif

    // shift beyond width_i+1 always rounds to zero, so clamp there instead of wrapping
    always_comb begin
        s_tot  = wt'(width_i - width_o) + wt'(shift_r);
        sc     = (s_tot > s_max) ? wi'(width_i + 1) : wi'(s_tot);
        ne     = {{2{num_r[width_i-1]}}, num_r};
        kept   = ne >>> sc;
        ext    = {ne, 1'b0};
        mask   = ((wn + 1)'(1) << sc) - (wn + 1)'(1);
        guard  = ext[sc];
        sticky = |(ext & mask);
        inc    = guard & (sticky | kept[0]);
        rnd    = {kept[wn-1], kept} + (wn + 1)'(inc);
        sat    = (rnd > max_v) ? max_v[width_o-1:0] :
                 (rnd < min_v) ? min_v[width_o-1:0] : rnd[width_o-1:0];
    end

    // registered result
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_rnd <= '0;
        else          o_rnd <= sat;
    end
endmodule

// File: tb/tb_shift_rnd_rne.sv
// tb_shift_rnd_rne: randomized and directed check of shift_rnd_rne against an arithmetic model.
module tb_shift_rnd_rne;
`ifdef SHIFT_RND_RNE_IN_REG_EN
    localparam int lat = 2;
`else
    localparam int lat = 1;
`endif
    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] num;
    logic [7:0] shift;
    logic [7:0] o_rnd;
    int         passed = 0;
    int         total = 0;
    string      tag_q[$];
    logic [7:0] exp_q[$];

    shift_rnd_rne dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_num(num),
        .i_shift(shift),
        .o_rnd(o_rnd)
    );

    always #5 clk = ~clk;

    // round-to-nearest-even of n / 2^(1+sh), clamped to the 8-bit signed range
    function automatic logic [7:0] model(input logic [8:0] n, input logic [7:0] sh);
        longint v, p, q, r;
        int s;
        v = longint'($signed(n));
        s = 1 + int'(sh);
        if (s > 40) s = 40;
        p = longint'(1) <<< s;
        q = v >>> s;
        r = v - q * p;
        if (2 * r > p || (2 * r == p && q[0])) q = q + 1;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q[7:0];
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step(input logic [8:0] n, input logic [7:0] s, input string tag);
        @(negedge clk);
        if (exp_q.size() == lat) chk(tag_q.pop_front(), o_rnd, exp_q.pop_front());
        num = n;
        shift = s;
        tag_q.push_back(tag);
        exp_q.push_back(model(n, s));
    endtask

    initial begin
        rst_n = 1'b0;
        num = 9'h055;
        shift = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_hold", o_rnd, 8'h00);
        rst_n = 1'b1;
        step(9'h004, 8'd0, "latency");
        step(9'h001, 8'd0, "tie_p1");
        step(9'h003, 8'd0, "tie_p3");
        step(9'h005, 8'd0, "tie_p5");
        step(9'h1FF, 8'd0, "tie_m1");
        step(9'h1FD, 8'd0, "tie_m3");
        step(9'h1FB, 8'd0, "tie_m5");
        step(9'h00C, 8'd2, "sh_1p5");
        step(9'h00D, 8'd2, "sh_1p625");
        step(9'h00A, 8'd2, "sh_1p25");
        step(9'h1F4, 8'd2, "sh_m1p5");
        step(9'h0FF, 8'd255, "big_pos");
        step(9'h100, 8'd255, "big_neg");
        step(9'h001, 8'd255, "big_one");
        step(9'h100, 8'd8, "half_neg");
        step(9'h100, 8'd7, "minus_one");
        step(9'h0FF, 8'd0, "sat_pos");
        step(9'h0FD, 8'd0, "near_top");
        step(9'h100, 8'd0, "most_neg");
        step(9'h0FF, 8'd1, "top_sh1");
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("async_rst", o_rnd, 8'h00);
        tag_q.delete();
        exp_q.delete();
        @(negedge clk);
        chk("rst_mid", o_rnd, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 4000; i++)
            step(9'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10)), "rand");
        repeat (lat) step(9'h000, 8'd0, "flush");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
